mul_share_sched: RTL
====================

// Module: mul_share_sched
// PURPOSE
//   Round-robin scheduler sharing one pipelined signed multiplier (32s x 28s -> low 32b, ce-gated,
//   input + output register) among NUM_REQ requesters in the SpMV PE datapath. Grants one operand
//   pair per cycle, drives the multiplier's ce/din0/din1 and tracks requester IDs through a tag
//   pipeline matched to the multiplier depth. Returns each product with its ID on one result channel.
// PARAMETERS
//   NUM_REQ   4   number of requesters, 2..16
//   A_W       32  signed operand A width (multiplier din0)
//   B_W       28  signed operand B width (multiplier din1)
//   P_W       32  product width (multiplier dout, low P_W bits of A*B)
//   MUL_LAT   2   ce-cycles from din presented to dout valid; must equal multiplier depth
// PORTS
//   clk        in   1            clock
//   reset      in   1            synchronous, active-high
//   req_valid  in   NUM_REQ      per-requester operand valid
//   req_ready  out  NUM_REQ      per-requester grant (one-hot or zero)
//   req_a      in   NUM_REQ*A_W  packed operand A, requester i at [i*A_W +: A_W]
//   req_b      in   NUM_REQ*B_W  packed operand B
//   res_valid  out  1            product valid
//   res_ready  in   1            downstream accepts product
//   res_id     out  ID_W         requester index of product, ID_W = $clog2(NUM_REQ)
//   res_data   out  P_W          product (mul_dout passthrough)
//   mul_ce     out  1            multiplier clock enable
//   mul_din0   out  A_W          multiplier operand A
//   mul_din1   out  B_W          multiplier operand B
//   mul_dout   in   P_W          multiplier result
// BEHAVIOUR
//   - Clock clk; reset synchronous, active-high. Reset: res_valid=0, tag pipe valids cleared,
//     rr pointer=0, stat counters=0. In-flight results discarded; multiplier data regs not reset.
//   - Stall: mul_ce = ~(res_valid & ~res_ready). When mul_ce=0, tag pipe holds, req_ready=0.
//   - Grant (comb.): if mul_ce, req_ready = one-hot of first req_valid[i] at or after ptr,
//     wrapping NUM_REQ-1 -> 0. req_ready may depend on req_valid; req_valid must not depend on ready.
//   - On handshake with requester g: ptr <= (g==NUM_REQ-1) ? 0 : g+1. No grant: ptr holds.
//   - mul_din0/din1 = granted requester's operands; zero when no grant (bubble, tag valid=0).
//   - Tag pipe: MUL_LAT stages of {valid,id}, shifted only when mul_ce=1. Last stage drives
//     res_valid/res_id; res_data = mul_dout. Full throughput: one product per cycle, no bubbles.
//   - Latency: handshake in cycle T -> res_valid in cycle T+MUL_LAT (no stalls); +1 per stall cycle.
//   - Outputs hold stable while res_valid & ~res_ready. Products return in grant order.
//   - Arithmetic: no width manipulation; truncation to P_W is the multiplier's.
// CONFIGURATION
//   MUL_SHARE_STATS_EN defined: extra outputs stat_grants[NUM_REQ*32] (per-requester handshake
//   count) and stat_stalls[32] (cycles with mul_ce=0); wrap modulo 2^32; cleared by reset.
//   Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//   Package mul_share_pkg: ID_W function ($clog2 with min 1), default widths, tag struct {valid,id}.
//   Sub-module mul_rr_arb: NUM_REQ round-robin arbiter (req, ptr, en -> one-hot gnt, gnt_idx).
//   Top: stall logic, operand mux, tag shift pipe, optional stats. Multiplier instanced by parent.
// TESTING (bench models multiplier as MUL_LAT ce-gated stages)
//   1. req0 only, a=-3, b=7, res_ready=1 -> req_ready[0] same cycle; res_valid 2 cycles later,
//      res_id=0, res_data=32'hFFFFFFEB.
//   2. All 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,...; one product/cycle,
//      ids in same order.
//   3. Pointer at 3, only req1 and req3 valid -> grant 3 then 1 (wrap), then 3.
//   4. res_ready=0 for 3 cycles with pipe full -> mul_ce=0, req_ready=0, res_* stable; no product
//      lost/duplicated after release.
//   5. Reset asserted with 2 products in flight -> next cycle res_valid=0, no stale products
//      emerge; first post-reset grant goes to req0.
//   6. MUL_SHARE_STATS_EN: 10 grants to req2 and 4 stall cycles -> stat_grants[2]=10, stat_stalls=4.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing scheduler.
// The tag id field is sized for the largest supported requester count (16).
package mul_share_pkg;

    localparam int unsigned DefNumReq = 4;
    localparam int unsigned DefAW     = 32;
    localparam int unsigned DefBW     = 28;
    localparam int unsigned DefPW     = 32;
    localparam int unsigned DefMulLat = 2;
    localparam int unsigned MaxIdW    = 4;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic              valid;
        logic [MaxIdW-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0. No grant when en_i is low.
module mul_rr_arb
    import mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned ID_W    = id_width(DefNumReq)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);

    logic            found;
    int unsigned     j;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j   = (32'(ptr_i) + k) % NUM_REQ;
            idx = ID_W'(j);
            if (en_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NUM_REQ requesters.
// Optional MUL_SHARE_STATS_EN adds per-requester grant and stall counters.
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned A_W     = DefAW,
    parameter int unsigned B_W     = DefBW,
    parameter int unsigned P_W     = DefPW,
    parameter int unsigned MUL_LAT = DefMulLat,
    localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [P_W-1:0]         res_data,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout
`ifdef MUL_SHARE_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]  stat_grants,
    output logic [31:0]            stat_stalls
`endif
);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               any_gnt;
    logic [ID_W-1:0]    ptr_q;
    tag_t               tag_d;
    tag_t               tag_q [MUL_LAT];
    logic [A_W-1:0]     a_arr [NUM_REQ];
    logic [B_W-1:0]     b_arr [NUM_REQ];
    logic               unused_tag_id;

    // Whole datapath freezes while a product waits on the result channel.
    assign mul_ce    = ~(res_valid & ~res_ready);
    assign any_gnt   = |gnt;
    assign req_ready = gnt;

    mul_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .en_i      (mul_ce),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*A_W +: A_W];
            b_arr[i] = req_b[i*B_W +: B_W];
        end
    end

    // Bubbles feed zeros so idle multiplier inputs stay deterministic.
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        if (any_gnt) begin
            mul_din0 = a_arr[gnt_idx];
            mul_din1 = b_arr[gnt_idx];
        end
    end

    always_comb begin
        tag_d       = '0;
        tag_d.valid = any_gnt;
        tag_d.id    = MaxIdW'(gnt_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else if (mul_ce) begin
            tag_q[0] <= tag_d;
            for (int unsigned k = 1; k < MUL_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (any_gnt) begin
            ptr_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign res_valid     = tag_q[MUL_LAT-1].valid;
    assign res_id        = tag_q[MUL_LAT-1].id[ID_W-1:0];
    assign res_data      = mul_dout;
    assign unused_tag_id = ^tag_q[MUL_LAT-1].id;

`ifdef MUL_SHARE_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            if (!mul_ce) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*32 +: 32] = grant_cnt_q[i];
        end
    end

    assign stat_stalls = stall_cnt_q;
`endif

endmodule
